rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
- Shares the single-port program ROM (8-bit word address, 16-bit data, 1-cycle registered read) between two requesters.
- Port A is instruction fetch. Port B is data (load-from-program-memory / debug readback).
- Fixed priority to A, with a burst limit that guarantees B forward progress.
- Returns read data tagged to the requester that was granted, and holds each port's last data until that port's next read completes.

Parameters:
- AW, 8, ROM word-address width.
- DW, 16, ROM data width.
- MAX_BURST, 4, max consecutive A grants while B is requesting before B is forced a grant (legal range 1..15).

Ports:
- clk  in  1  system clock, all logic on posedge.
- i_rst_n  in  1  synchronous active-low reset.
- i_a_req  in  1  port A read request; held with i_a_addr until o_a_gnt.
- i_a_addr  in  AW  port A word address.
- o_a_gnt  out  1  combinational, A's request is issued to ROM this cycle.
- o_a_rvalid  out  1  registered, o_a_rdata updated this cycle.
- o_a_rdata  out  DW  port A read data, held between reads.
- i_b_req  in  1  port B read request (same rules as A).
- i_b_addr  in  AW  port B word address.
- o_b_gnt  out  1  port B grant.
- o_b_rvalid  out  1  port B data valid.
- o_b_rdata  out  DW  port B read data, held.
- o_rom_rd  out  1  ROM read enable (to ROM i_rd).
- o_rom_raddr  out  AW  ROM address (to ROM i_raddr).
- i_rom_rdata  in  DW  ROM data (from ROM o_rdata), valid the cycle after o_rom_rd.
- o_busy  out  1  registered, a ROM read is in flight (rdata due this cycle).

Behaviour:
- Reset (i_rst_n=0 at posedge):
  - o_a_rvalid, o_b_rvalid, o_busy = 0; o_a_rdata, o_b_rdata = 0.
  - Burst counter = 0; owner tag = A.
  - While reset is asserted, o_a_gnt, o_b_gnt and o_rom_rd are forced 0.
- Arbitration (combinational, every cycle):
  - Only A requesting: A wins.
  - Only B requesting: B wins.
  - Both requesting: A wins unless burst_cnt == MAX_BURST, in which case B wins.
  - Exactly one gnt per cycle at most; o_rom_rd = o_a_gnt | o_b_gnt.
  - o_rom_raddr = winner's address; when idle it holds the last issued address (registered mux select).
- Throughput: one ROM read per cycle, and back-to-back grants are allowed.
- Latency: gnt in cycle T, then rvalid and rdata in cycle T+1.
  - Owner tag is registered at T and steers i_rom_rdata into the owner's rdata register.
  - The owner's rvalid pulses for exactly one cycle at T+1.
  - The non-owner's rdata is unchanged.
- Burst counter (4 bits):
  - A granted while i_b_req=1: increment (saturate at MAX_BURST).
  - B granted, or i_b_req=0: clear to 0.
  - A granted with B idle does not count.
- Request rules:
  - A requester deasserting req before gnt is legal (request withdrawn, no access).
  - An address change while waiting is legal; the address sampled in the gnt cycle is used.
- o_busy = registered o_rom_rd.
- Reset mid-operation (reset in cycle T+1 of an in-flight read):
  - The read is discarded; no rvalid is emitted and rdata is not updated.
  - The first grant after reset is issued no earlier than the first cycle with i_rst_n=1.
- No state machine beyond two things:
  - A 1-deep in-flight pipeline stage (valid + owner).
  - The burst counter.

Decomposition:
- Package rom_pkg holds:
  - ROM_AW = 8 and ROM_DW = 16 localparams.
  - typedef enum logic {OWN_A, OWN_B} rom_owner_t.
  - typedef logic [ROM_DW-1:0] rom_word_t.
- Sub-module rom_arb_prio holds the combinational priority/burst-override select, so it can be unit-tested.
- The top module holds the registers and data steering.
- The ROM itself is instantiated outside, at the fetch-stage level.

Test Plan:
- Reset then A-only reads of addresses 0..7 back-to-back:
  - gnt every cycle, and o_a_rvalid one cycle later each time.
  - o_a_rdata equals the program.mem line at each address.
  - o_b_rvalid stays 0.
- B-only read of addr 0x10 -> o_b_gnt same cycle, o_b_rvalid at +1, o_b_rdata = mem[0x10]; o_a_rdata unchanged.
- A and B both requesting continuously, MAX_BURST=4 -> grant pattern A,A,A,A,B repeating, and each rdata matches its own address.
- B withdraws req after 2 waiting cycles -> burst counter clears, and the next contention again allows 4 A grants.
- Reset asserted in the cycle after an A grant to addr 0x05:
  - No o_a_rvalid, and o_a_rdata = 0.
  - After reset release, an A read of 0x05 returns mem[0x05] at +1.
- A gnt at addr 0x03 then idle for 3 cycles:
  - o_a_rdata holds mem[0x03], o_a_rvalid is 0 in the idle cycles.
  - o_busy = 1 only in the cycle after the gnt.

Source files
------------

// File: rtl/rom_pkg.sv
// Shared types and widths for the program-ROM arbiter slice.
package rom_pkg;

   localparam int ROM_AW = 8;
   localparam int ROM_DW = 16;

   // Which requester the in-flight ROM read belongs to.
   typedef enum logic {OWN_A, OWN_B} rom_owner_t;

   typedef logic [ROM_DW-1:0] rom_word_t;

endpackage : rom_pkg

// File: rtl/rom_arb_prio.sv
// Priority select between fetch (A) and data (B) requesters.
// A wins by default; once A has taken MAX_BURST grants in a row while B
// was waiting, B is forced through so data reads cannot starve.
module rom_arb_prio #(
   parameter int MAX_BURST = 4
) (
   input  logic       a_req,
   input  logic       b_req,
   input  logic [3:0] burst_cnt,
   output logic       a_win,
   output logic       b_win
);

   logic force_b;

   // Combinational winner select; at most one of a_win/b_win is ever set.
   always_comb begin
      force_b = b_req && (burst_cnt == 4'(MAX_BURST));
      a_win   = a_req && !force_b;
      b_win   = b_req && !a_win;
   end

endmodule : rom_arb_prio

// File: rtl/rom_arbiter.sv
// Shares the single-port program ROM between instruction fetch (A) and
// data/debug readback (B). The ROM has a one-cycle registered read, so a
// grant in cycle T returns data on i_rom_rdata in cycle T+1; that data is
// steered to the granted port and also captured so each port holds its
// last read value until its next read completes.
module rom_arbiter
   import rom_pkg::*;
#(
   parameter int AW        = ROM_AW,
   parameter int DW        = ROM_DW,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          i_rst_n,
   input  logic          i_a_req,
   input  logic [AW-1:0] i_a_addr,
   output logic          o_a_gnt,
   output logic          o_a_rvalid,
   output logic [DW-1:0] o_a_rdata,
   input  logic          i_b_req,
   input  logic [AW-1:0] i_b_addr,
   output logic          o_b_gnt,
   output logic          o_b_rvalid,
   output logic [DW-1:0] o_b_rdata,
   output logic          o_rom_rd,
   output logic [AW-1:0] o_rom_raddr,
   input  logic [DW-1:0] i_rom_rdata,
   output logic          o_busy
);

   logic          a_win;
   logic          b_win;
   logic          inflight_q;
   rom_owner_t    owner_q;
   logic [3:0]    burst_cnt_q;
   logic [AW-1:0] last_addr_q;
   logic [DW-1:0] a_data_q;
   logic [DW-1:0] b_data_q;
   logic          a_done;
   logic          b_done;

   rom_arb_prio #(
      .MAX_BURST (MAX_BURST)
   ) u_prio (
      .a_req     (i_a_req),
      .b_req     (i_b_req),
      .burst_cnt (burst_cnt_q),
      .a_win     (a_win),
      .b_win     (b_win)
   );

   // Grants, ROM strobe/address and read-return steering.
   // NOTE: i_rst_n also gates the combinational grants and completions, so
   // nothing is issued during reset and a read whose data returns while
   // reset is asserted is dropped rather than delivered.
   always_comb begin
      o_a_gnt     = a_win & i_rst_n;
      o_b_gnt     = b_win & i_rst_n;
      o_rom_rd    = o_a_gnt | o_b_gnt;
      o_rom_raddr = o_a_gnt ? i_a_addr : (o_b_gnt ? i_b_addr : last_addr_q);

      a_done      = inflight_q && (owner_q == OWN_A) && i_rst_n;
      b_done      = inflight_q && (owner_q == OWN_B) && i_rst_n;
      o_a_rvalid  = a_done;
      o_b_rvalid  = b_done;
      o_a_rdata   = a_done ? i_rom_rdata : a_data_q;
      o_b_rdata   = b_done ? i_rom_rdata : b_data_q;
      o_busy      = inflight_q;
   end

   // In-flight stage, owner tag, held read data and the A burst counter.
   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         inflight_q  <= 1'b0;
         owner_q     <= OWN_A;
         burst_cnt_q <= '0;
         last_addr_q <= '0;
         a_data_q    <= '0;
         b_data_q    <= '0;
      end else begin
         inflight_q <= o_rom_rd;
         if (o_rom_rd) begin
            owner_q     <= o_b_gnt ? OWN_B : OWN_A;
            last_addr_q <= o_rom_raddr;
         end

         if (a_done) a_data_q <= i_rom_rdata;
         if (b_done) b_data_q <= i_rom_rdata;

         // Count only A grants that made B wait; any B grant or B going
         // idle restarts the burst window.
         if (!i_b_req || o_b_gnt) begin
            burst_cnt_q <= '0;
         end else if (o_a_gnt && (burst_cnt_q != 4'(MAX_BURST))) begin
            burst_cnt_q <= burst_cnt_q + 4'd1;
         end
      end
   end

endmodule : rom_arbiter

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter with a behavioural ROM and a
// reference model of the arbitration and return rules.
module tb_rom_arbiter;
   import rom_pkg::*;

   localparam int AW        = ROM_AW;
   localparam int DW        = ROM_DW;
   localparam int MAX_BURST = 4;

   logic          clk = 1'b0;
   logic          i_rst_n;
   logic          i_a_req;
   logic [AW-1:0] i_a_addr;
   logic          o_a_gnt;
   logic          o_a_rvalid;
   logic [DW-1:0] o_a_rdata;
   logic          i_b_req;
   logic [AW-1:0] i_b_addr;
   logic          o_b_gnt;
   logic          o_b_rvalid;
   logic [DW-1:0] o_b_rdata;
   logic          o_rom_rd;
   logic [AW-1:0] o_rom_raddr;
   logic [DW-1:0] i_rom_rdata;
   logic          o_busy;

   always #5 clk = ~clk;

   rom_arbiter #(
      .AW        (AW),
      .DW        (DW),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk         (clk),
      .i_rst_n     (i_rst_n),
      .i_a_req     (i_a_req),
      .i_a_addr    (i_a_addr),
      .o_a_gnt     (o_a_gnt),
      .o_a_rvalid  (o_a_rvalid),
      .o_a_rdata   (o_a_rdata),
      .i_b_req     (i_b_req),
      .i_b_addr    (i_b_addr),
      .o_b_gnt     (o_b_gnt),
      .o_b_rvalid  (o_b_rvalid),
      .o_b_rdata   (o_b_rdata),
      .o_rom_rd    (o_rom_rd),
      .o_rom_raddr (o_rom_raddr),
      .i_rom_rdata (i_rom_rdata),
      .o_busy      (o_busy)
   );

   // Program ROM: one-cycle registered read, output held when not reading.
   logic [DW-1:0] mem [256];
   logic [DW-1:0] rom_q = '0;
   always @(posedge clk) if (o_rom_rd) rom_q <= mem[o_rom_raddr];
   assign i_rom_rdata = rom_q;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   int            streak;      // A grants in a row while B waited
   bit            pend_v;      // a read was granted last cycle
   bit            pend_b;      // ...and it belonged to B
   logic [AW-1:0] pend_addr;
   logic [DW-1:0] a_hold;
   logic [DW-1:0] b_hold;
   int            a_grants;
   int            b_grants;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check every output against the model,
   // advance the model, then move to just after the next rising edge.
   task automatic step(input bit rst, input bit ar, input logic [AW-1:0] aa,
                       input bit br, input logic [AW-1:0] ba);
      bit            ea, eb, eav, ebv;
      logic [DW-1:0] ead, ebd;
      i_rst_n  = rst;
      i_a_req  = ar;
      i_a_addr = aa;
      i_b_req  = br;
      i_b_addr = ba;
      #1;
      ea  = rst && ar && !(br && streak == MAX_BURST);
      eb  = rst && br && !ea;
      eav = rst && pend_v && !pend_b;
      ebv = rst && pend_v && pend_b;
      ead = eav ? mem[pend_addr] : a_hold;
      ebd = ebv ? mem[pend_addr] : b_hold;

      check("a_gnt",    32'(o_a_gnt),    32'(ea));
      check("b_gnt",    32'(o_b_gnt),    32'(eb));
      check("rom_rd",   32'(o_rom_rd),   32'(ea || eb));
      if (ea) check("raddr_a", 32'(o_rom_raddr), 32'(aa));
      if (eb) check("raddr_b", 32'(o_rom_raddr), 32'(ba));
      check("a_rvalid", 32'(o_a_rvalid), 32'(eav));
      check("b_rvalid", 32'(o_b_rvalid), 32'(ebv));
      check("a_rdata",  32'(o_a_rdata),  32'(ead));
      check("b_rdata",  32'(o_b_rdata),  32'(ebd));
      check("busy",     32'(o_busy),     32'(pend_v));

      if (!rst) begin
         streak = 0;
         pend_v = 1'b0;
         pend_b = 1'b0;
         a_hold = '0;
         b_hold = '0;
      end else begin
         if (eav) a_hold = ead;
         if (ebv) b_hold = ebd;
         if (!br || eb)   streak = 0;
         else if (ea)     streak = (streak < MAX_BURST) ? streak + 1 : streak;
         pend_v    = ea || eb;
         pend_b    = eb;
         pend_addr = eb ? ba : aa;
      end
      if (ea) a_grants++;
      if (eb) b_grants++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
      streak = 0; pend_v = 1'b0; pend_b = 1'b0; pend_addr = '0;
      a_hold = '0; b_hold = '0; a_grants = 0; b_grants = 0;
      i_rst_n = 1'b0; i_a_req = 1'b0; i_a_addr = '0; i_b_req = 1'b0; i_b_addr = '0;
      @(posedge clk);
      #1;

      // Reset held with both ports requesting: no grants, outputs cleared.
      step(1'b0, 1'b1, 8'h01, 1'b1, 8'h02);
      step(1'b0, 1'b1, 8'h01, 1'b1, 8'h02);

      // A-only back-to-back reads of 0..7.
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, AW'(i), 1'b0, 8'h00);
      step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);

      // B-only read of 0x10; A data must stay put.
      step(1'b1, 1'b0, 8'h00, 1'b1, 8'h10);
      step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);

      // Continuous contention: A,A,A,A,B repeating.
      a_grants = 0; b_grants = 0;
      for (int i = 0; i < 15; i++) step(1'b1, 1'b1, AW'(8'h20 + i), 1'b1, AW'(8'h40 + i));
      check("burst_a_count", 32'(a_grants), 32'd12);
      check("burst_b_count", 32'(b_grants), 32'd3);
      step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);

      // B waits 2 cycles then withdraws; the next contention gets 4 A grants.
      step(1'b1, 1'b1, 8'h50, 1'b1, 8'h60);
      step(1'b1, 1'b1, 8'h51, 1'b1, 8'h60);
      step(1'b1, 1'b1, 8'h52, 1'b0, 8'h60);
      a_grants = 0; b_grants = 0;
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, AW'(8'h53 + i), 1'b1, 8'h61);
      check("withdraw_a_count", 32'(a_grants), 32'd4);
      check("withdraw_b_count", 32'(b_grants), 32'd1);
      step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);

      // Reset in the cycle after an A grant to 0x05: read is discarded.
      step(1'b1, 1'b1, 8'h05, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h05, 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'h05, 1'b0, 8'h00);
      step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);

      // A read of 0x03 followed by 3 idle cycles: data held, busy once.
      step(1'b1, 1'b1, 8'h03, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), AW'($urandom),
              ($urandom_range(0, 1) != 0), AW'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_rom_arbiter
